// File: rtl/keychain_pkg.sv
// Shared types and constants for the modular-exponentiation datapath.
package keychain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LAUNCH,
    WAIT,
    STEP,
    DONE
  } mod_exp_state_t;

  localparam int ACC_INIT = 1;

endpackage

// File: rtl/modulus.sv
// Sequential reduction of a 2*WIDTH-bit value modulo a WIDTH-bit modulus (restoring, one bit per cycle).
module modulus #(
  parameter int WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               ready_in,
  input  logic [2*WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0]   modulus_in,
  output logic [WIDTH-1:0]   result_out,
  output logic               valid_out
);

  localparam int CW = $clog2(2*WIDTH+1);

  logic [2*WIDTH-1:0] x;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [CW-1:0]      cnt;
  logic               busy;

  // rem stays below m, so one extra bit covers the shifted partial remainder.
  always_comb begin
    shifted  = {rem, x[2*WIDTH-1]};
    diff     = shifted - {1'b0, m};
    rem_next = (shifted >= {1'b0, m}) ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk_in) begin
    valid_out <= 1'b0;
    if (rst_in) begin
      x          <= '0;
      m          <= '0;
      rem        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      result_out <= '0;
    end else if (busy) begin
      x   <= x << 1;
      rem <= rem_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy       <= 1'b0;
        result_out <= rem_next;
        valid_out  <= 1'b1;
      end
    end else if (ready_in) begin
      x    <= value_in;
      m    <= modulus_in;
      rem  <= '0;
      cnt  <= CW'(2*WIDTH);
      busy <= 1'b1;
    end
  end

endmodule

// File: rtl/square.sv
// Square-mod stage: value_in is sampled one cycle after ready_in, squared, then reduced.
module square #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] square_out,
  output logic             valid_out
);

  logic               pend;
  logic               go;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend <= 1'b0;
      go   <= 1'b0;
      prod <= '0;
    end else begin
      pend <= ready_in;
      go   <= pend;
      if (pend) prod <= {{WIDTH{1'b0}}, value_in} * {{WIDTH{1'b0}}, value_in};
    end
  end

  modulus #(.WIDTH(WIDTH)) u_reduce (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ready_in   (go),
    .value_in   (prod),
    .modulus_in (modulus_in),
    .result_out (square_out),
    .valid_out  (valid_out)
  );

endmodule

// File: rtl/mod_exp.sv
// Right-to-left square-and-multiply modular exponentiation driving a square stage and an acc*b reducer.
module mod_exp
  import keychain_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] exponent_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] result_out,
  output logic             busy_out,
  output logic             valid_out,
  output mod_exp_state_t   state_out
);

  mod_exp_state_t     state;
  logic [WIDTH-1:0]   b, e, m, acc;
  logic [2*WIDTH-1:0] prod;
  logic               mul_go, sq_go;
  logic               mul_issued, sq_issued, mul_done, sq_done;
  logic [WIDTH-1:0]   mul_res, sq_res, mul_val, sq_val;
  logic               mul_valid, sq_valid;

  assign state_out = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      b          <= '0;
      e          <= '0;
      m          <= '0;
      acc        <= '0;
      prod       <= '0;
      mul_go     <= 1'b0;
      sq_go      <= 1'b0;
      mul_issued <= 1'b0;
      sq_issued  <= 1'b0;
      mul_done   <= 1'b0;
      sq_done    <= 1'b0;
      mul_res    <= '0;
      sq_res     <= '0;
      result_out <= '0;
      busy_out   <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      mul_go    <= 1'b0;
      sq_go     <= 1'b0;
      valid_out <= 1'b0;
      case (state)
        IDLE: if (ready_in) begin
          b        <= base_in;
          e        <= exponent_in;
          m        <= modulus_in;
          acc      <= WIDTH'(ACC_INIT);
          busy_out <= 1'b1;
          state    <= CHECK;
        end
        CHECK: begin
          // acc already holds 1 for the e==0 case; m<=1 forces 0.
          if (m <= WIDTH'(1)) begin
            acc   <= '0;
            state <= DONE;
          end else if (e == '0) begin
            state <= DONE;
          end else begin
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          prod       <= {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, b};
          mul_go     <= e[0];
          sq_go      <= |e[WIDTH-1:1];
          mul_issued <= e[0];
          sq_issued  <= |e[WIDTH-1:1];
          mul_done   <= 1'b0;
          sq_done    <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (mul_valid) begin
            mul_res  <= mul_val;
            mul_done <= 1'b1;
          end
          if (sq_valid) begin
            sq_res  <= sq_val;
            sq_done <= 1'b1;
          end
          if ((mul_done || mul_valid || !mul_issued) && (sq_done || sq_valid || !sq_issued))
            state <= STEP;
        end
        STEP: begin
          if (mul_issued) acc <= mul_res;
          if (sq_issued) b <= sq_res;
          e     <= e >> 1;
          state <= (e[WIDTH-1:1] == '0) ? DONE : LAUNCH;
        end
        DONE: begin
          result_out <= acc;
          busy_out   <= 1'b0;
          valid_out  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  modulus #(.WIDTH(WIDTH)) u_mult_mod (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ready_in   (mul_go),
    .value_in   (prod),
    .modulus_in (m),
    .result_out (mul_val),
    .valid_out  (mul_valid)
  );

  square #(.WIDTH(WIDTH)) u_square (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ready_in   (sq_go),
    .value_in   (b),
    .modulus_in (m),
    .square_out (sq_val),
    .valid_out  (sq_valid)
  );

endmodule
